// File: rtl/reflet_uart_loader.sv
// Boot loader: receives LEN, LEN data bytes and CHK over 8N1 UART, writes them into the
// instruction RAM and releases the CPU reset once the checksum matches.
module reflet_uart_loader #(
    parameter int clk_freq  = 1000000,
    parameter int baud_rate = 9600,
    parameter int mem_size  = 128
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rx,
    output logic [$clog2(mem_size)-1:0] addr,
    output logic [7:0]                  data_out,
    output logic                        write_en,
    output logic                        cpu_reset,
    output logic                        busy,
    output logic                        done,
    output logic                        error
);
    localparam int P    = clk_freq / baud_rate;
    localparam int HALF = P / 2;
    localparam int CW   = $clog2(P);
    localparam int AW   = $clog2(mem_size);
    localparam logic [CW-1:0] LAST      = CW'(P - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic [8:0]    MEM_N     = 9'(mem_size);

    // ---------------- 8N1 receiver ----------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

    rx_state_t       rstate;
    logic            rx_s1, rx_s2, rx_d;
    logic [CW-1:0]   cnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            fall, start_ok, stop_tick, byte_valid, frame_err;

    assign fall       = rx_d & ~rx_s2;
    assign start_ok   = (rstate == R_START) && (cnt == HALF_LAST) && !rx_s2;
    assign stop_tick  = (rstate == R_STOP) && (cnt == LAST);
    assign byte_valid = stop_tick & rx_s2;
    assign frame_err  = stop_tick & ~rx_s2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_d    <= 1'b1;
            rstate  <= R_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
            case (rstate)
                R_IDLE: begin
                    if (fall) begin
                        rstate <= R_START;
                        cnt    <= '0;
                    end
                end
                R_START: begin
                    // mid-bit recheck rejects short glitches as false starts
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        rstate  <= rx_s2 ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                R_DATA: begin
                    if (cnt == LAST) begin
                        cnt     <= '0;
                        shreg   <= {rx_s2, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) rstate <= R_STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                R_STOP: begin
                    if (cnt == LAST) begin
                        cnt    <= '0;
                        rstate <= R_IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

    // ---------------- loader FSM ----------------
    typedef enum logic [2:0] {S_WAIT_LEN, S_LOAD, S_CHECK, S_DONE, S_ERROR} state_t;

    state_t     state;
    logic [7:0] len, idx, sum;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_WAIT_LEN;
            len       <= '0;
            idx       <= '0;
            sum       <= '0;
            addr      <= '0;
            data_out  <= '0;
            write_en  <= 1'b0;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            write_en <= 1'b0;
            case (state)
                S_WAIT_LEN: begin
                    if (start_ok) busy <= 1'b1;
                    if (frame_err) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        sum <= '0;
                        idx <= '0;
                        if (shreg == 8'd0) begin
                            state <= S_CHECK;
                        end else if ({1'b0, shreg} > MEM_N) begin
                            state <= S_ERROR;
                            error <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            len   <= shreg;
                            state <= S_LOAD;
                        end
                    end
                end
                S_LOAD: begin
                    if (frame_err) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        write_en <= 1'b1;
                        addr     <= idx[AW-1:0];
                        data_out <= shreg;
                        sum      <= sum + shreg;
                        idx      <= idx + 8'd1;
                        if (idx + 8'd1 == len) state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (frame_err || (byte_valid && shreg != sum)) begin
                        state <= S_ERROR;
                        error <= 1'b1;
                        busy  <= 1'b0;
                    end else if (byte_valid) begin
                        state     <= S_DONE;
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        cpu_reset <= 1'b1;
                    end
                end
                default: ; // DONE and ERROR are terminal until reset
            endcase
        end
    end
endmodule

// File: tb/tb_reflet_uart_loader.sv
// Directed bench for the UART boot loader (P = 10 clock cycles per bit).
module tb_reflet_uart_loader;
    localparam int P = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic [6:0] addr;
    logic [7:0] data_out;
    logic       write_en, cpu_reset, busy, done, error;

    int checks = 0;
    int failures = 0;

    int         wr_total = 0;
    logic [6:0] log_addr [0:511];
    logic [7:0] log_data [0:511];

    reflet_uart_loader #(.clk_freq(1000000), .baud_rate(100000), .mem_size(128)) dut (
        .clk(clk), .reset(reset), .rx(rx), .addr(addr), .data_out(data_out),
        .write_en(write_en), .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (write_en) begin
            log_addr[wr_total] <= addr;
            log_data[wr_total] <= data_out;
            wr_total <= wr_total + 1;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rx = 1'b1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v);
        rx = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (P) @(negedge clk);
        end
        rx = stop_v;
        repeat (P) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_byte(b, 1'b1);
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [20:0] got;
        do_reset();
        got = {addr, data_out, write_en, cpu_reset, busy, done, error};
        checks++;
        if (got !== 21'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=000000", got);
        end
    endtask

    task automatic test_load_ok();
        logic [7:0] exp_d [0:2];
        int base;
        exp_d[0] = 8'h11; exp_d[1] = 8'h22; exp_d[2] = 8'h33;
        do_reset();
        base = wr_total;
        send(8'h03);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL load_busy got=%b exp=1", busy); end
        send_byte(8'h11, 1'b1);
        checks++;
        if (wr_total - base !== 1) begin
            failures++; $display("FAIL load_latency writes=%0d exp=1", wr_total - base);
        end
        repeat (3) @(negedge clk);
        send(8'h22);
        send(8'h33);
        checks++;
        if (done !== 1'b0) begin failures++; $display("FAIL load_early_done got=%b exp=0", done); end
        send(8'h66);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_total - base !== 3) begin
            failures++; $display("FAIL load_count got=%0d exp=3", wr_total - base);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (log_addr[base+i] !== 7'(i) || log_data[base+i] !== exp_d[i]) begin
                failures++;
                $display("FAIL load_write%0d got=%h/%h exp=%h/%h", i, log_addr[base+i],
                         log_data[base+i], 7'(i), exp_d[i]);
            end
        end
        checks++;
        if ({done, cpu_reset, error, busy} !== 4'b1100) begin
            failures++;
            $display("FAIL load_status got=%b exp=1100", {done, cpu_reset, error, busy});
        end
        send(8'h05);
        checks++;
        if (wr_total - base !== 3 || done !== 1'b1) begin
            failures++; $display("FAIL done_ignore_rx writes=%0d done=%b", wr_total - base, done);
        end
    endtask

    task automatic test_bad_chk();
        int base;
        do_reset();
        base = wr_total;
        send(8'h02); send(8'h80); send(8'h90); send(8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_total - base !== 2 || log_data[base+1] !== 8'h90 || log_addr[base+1] !== 7'd1) begin
            failures++;
            $display("FAIL badchk_writes got=%0d last=%h exp=2 last=90", wr_total - base, log_data[base+1]);
        end
        checks++;
        if ({error, cpu_reset, done, busy} !== 4'b1000) begin
            failures++;
            $display("FAIL badchk_status got=%b exp=1000", {error, cpu_reset, done, busy});
        end
        send(8'h01); send(8'h44);
        checks++;
        if (wr_total - base !== 2 || error !== 1'b1) begin
            failures++; $display("FAIL error_ignore_rx writes=%0d err=%b", wr_total - base, error);
        end
    endtask

    task automatic test_len_over();
        int base;
        do_reset();
        base = wr_total;
        send(8'h81);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_total - base !== 0 || {error, done, cpu_reset} !== 3'b100) begin
            failures++;
            $display("FAIL len_over writes=%0d status=%b exp=0 100", wr_total - base, {error, done, cpu_reset});
        end
    endtask

    task automatic test_full();
        int base;
        do_reset();
        base = wr_total;
        send(8'h80);
        for (int i = 0; i < 128; i++) send(8'hFF);
        send(8'h80);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_total - base !== 128) begin
            failures++; $display("FAIL full_count got=%0d exp=128", wr_total - base);
        end
        checks++;
        if (log_addr[base] !== 7'h00 || log_addr[base+127] !== 7'h7F || log_data[base+127] !== 8'hFF) begin
            failures++;
            $display("FAIL full_addr first=%h last=%h data=%h exp=00 7f ff",
                     log_addr[base], log_addr[base+127], log_data[base+127]);
        end
        checks++;
        if ({done, cpu_reset, error} !== 3'b110) begin
            failures++; $display("FAIL full_status got=%b exp=110", {done, cpu_reset, error});
        end
    endtask

    task automatic test_glitch();
        int base;
        do_reset();
        base = wr_total;
        rx = 1'b0;
        repeat (3) @(negedge clk);
        rx = 1'b1;
        repeat (3 * P * 10) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || error !== 1'b0 || wr_total - base !== 0) begin
            failures++;
            $display("FAIL glitch busy=%b err=%b writes=%0d exp=0 0 0", busy, error, wr_total - base);
        end
        // the loader must still accept a proper frame afterwards
        send(8'h01); send(8'h5A); send(8'h5A);
        repeat (2) @(negedge clk);
        checks++;
        if (done !== 1'b1 || wr_total - base !== 1 || log_data[base] !== 8'h5A) begin
            failures++;
            $display("FAIL glitch_recover done=%b writes=%0d exp=1 1", done, wr_total - base);
        end
    endtask

    task automatic test_framing();
        int base;
        do_reset();
        base = wr_total;
        send(8'h02);
        send(8'hAA);
        send_byte(8'hBB, 1'b0);
        repeat (5) @(negedge clk);
        checks++;
        if (wr_total - base !== 1 || {error, busy, cpu_reset, done} !== 4'b1000) begin
            failures++;
            $display("FAIL framing writes=%0d status=%b exp=1 1000", wr_total - base,
                     {error, busy, cpu_reset, done});
        end
    endtask

    task automatic test_reset_mid();
        int base;
        do_reset();
        base = wr_total;
        send(8'h05);
        rx = 1'b0;
        repeat (P) @(negedge clk);
        rx = 1'b1; repeat (P) @(negedge clk);
        rx = 1'b0; repeat (P) @(negedge clk);
        rx = 1'b1; repeat (P / 2) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before got=%b exp=1", busy); end
        reset = 1'b0;
        #1;
        checks++;
        if ({busy, cpu_reset, done, error, write_en} !== 5'b0) begin
            failures++;
            $display("FAIL midreset_clear got=%b exp=00000", {busy, cpu_reset, done, error, write_en});
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h00);
        send(8'h00);
        repeat (2) @(negedge clk);
        checks++;
        if (wr_total - base !== 0 || {done, cpu_reset, error} !== 3'b110) begin
            failures++;
            $display("FAIL midreset_len0 writes=%0d status=%b exp=0 110", wr_total - base,
                     {done, cpu_reset, error});
        end
    endtask

    initial begin
        test_reset();
        test_load_ok();
        test_bad_chk();
        test_len_over();
        test_full();
        test_glitch();
        test_framing();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
